// File: rtl/mem_resp_packer_pkg.sv
// Shared types and widths for the nibble-to-byte response packer.
package mem_pkt_pkg;

  typedef enum logic {
    LOW  = 1'b0,
    HIGH = 1'b1
  } pack_state_e;

  localparam int COV_W       = 6;
  localparam int COV_ENTRIES = 64;
  localparam int NIB_W       = 4;
  localparam int BYTE_W      = 8;

  // Coverage tuple layout: {fsm, fifo count, idle counter}.
  function automatic logic [COV_W-1:0] cov_tuple(input pack_state_e fsm,
                                                 input logic [2:0]  count,
                                                 input logic [1:0]  idle);
    return {fsm, count, idle};
  endfunction

endpackage

// File: rtl/mem_resp_packer_if.sv
// Nibble input strobe and byte output valid/ready port of the packer.
interface mem_resp_packer_if;
  import mem_pkt_pkg::*;

  logic              in_valid;
  logic [NIB_W-1:0]  in_data;
  logic              out_valid;
  logic [BYTE_W-1:0] out_data;
  logic              out_ready;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output out_valid,
    output out_data
  );

endinterface

// File: rtl/mem_resp_packer_fifo.sv
// Show-ahead byte FIFO: head is combinational from the read pointer entry.
module byte_fifo
  import mem_pkt_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic [BYTE_W-1:0] push_data,
  input  logic              pop,
  output logic [BYTE_W-1:0] head,
  output logic              full,
  output logic              empty,
  output logic [2:0]        count,
  output logic              ovf
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [BYTE_W-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [2:0]        count_reg;
  logic              pop_ok;
  logic              push_ok;

  assign empty   = (count_reg == 3'd0);
  assign full    = (count_reg == 3'(DEPTH));
  assign pop_ok  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push_ok = push && (!full || pop_ok);
  assign ovf     = push && !push_ok;
  assign count   = count_reg;
  assign head    = mem_reg[rd_ptr_reg];

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clock) begin
        if (push_ok && (wr_ptr_reg == PTR_W'(gi))) begin
          mem_reg[gi] <= push_data;
        end
      end
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= 3'd0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 3'd1;
        2'b01:   count_reg <= count_reg - 3'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/mem_resp_packer.sv
// Packs the mem_ctrl nibble stream into bytes (low nibble first), queues them
// in a show-ahead FIFO and tracks a {fsm, count, idle} state-coverage map.
module mem_resp_packer
  import mem_pkt_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             meta_reset,
  mem_resp_packer_if.slave bus,
  output logic [3:0]       drop_cnt,
  output logic [COV_W-1:0] coverage,
  output logic [COV_W-1:0] io_cov_sum,
  output logic             bug
);
  localparam logic [1:0] IDLE_LAST = 2'(TIMEOUT - 1);

  generate
    if (!(DEPTH == 2 || DEPTH == 4)) begin : g_bad_depth
      $error("mem_resp_packer: DEPTH must be 2 or 4");
    end
    if (TIMEOUT < 1 || TIMEOUT > 3) begin : g_bad_timeout
      $error("mem_resp_packer: TIMEOUT must be 1..3");
    end
  endgenerate

  pack_state_e       state_reg;
  pack_state_e       state_next;
  logic [NIB_W-1:0]  lo_reg;
  logic [NIB_W-1:0]  lo_next;
  logic [1:0]        idle_reg;
  logic [1:0]        idle_next;
  logic              push_valid;
  logic [BYTE_W-1:0] push_byte;

  logic [BYTE_W-1:0] fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic [2:0]        fifo_count;
  logic              fifo_ovf;

  logic [3:0]        drop_cnt_reg;
  logic              bug_reg;

  logic [COV_W-1:0]       cov_state_reg = '0;
  logic [COV_ENTRIES-1:0] covmap_reg    = '0;
  logic [COV_W-1:0]       covsum_reg    = '0;

  always_comb begin
    state_next = state_reg;
    lo_next    = lo_reg;
    idle_next  = idle_reg;
    push_valid = 1'b0;
    push_byte  = '0;
    case (state_reg)
      LOW: begin
        if (bus.in_valid) begin
          lo_next    = bus.in_data;
          idle_next  = 2'd0;
          state_next = HIGH;
        end
      end
      HIGH: begin
        if (bus.in_valid) begin
          push_valid = 1'b1;
          push_byte  = {bus.in_data, lo_reg};
          state_next = LOW;
        end else if (idle_reg == IDLE_LAST) begin
          // Producer went quiet mid-byte: flush with a zero high nibble.
          push_valid = 1'b1;
          push_byte  = {{NIB_W{1'b0}}, lo_reg};
          idle_next  = 2'd0;
          state_next = LOW;
        end else begin
          idle_next  = idle_reg + 2'd1;
        end
      end
      default: state_next = LOW;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= LOW;
      lo_reg    <= '0;
      idle_reg  <= 2'd0;
    end else begin
      state_reg <= state_next;
      lo_reg    <= lo_next;
      idle_reg  <= idle_next;
    end
  end

  byte_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (push_valid),
    .push_data(push_byte),
    .pop      (bus.out_ready),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count),
    .ovf      (fifo_ovf)
  );

  assign bus.out_valid = !fifo_empty;
  assign bus.out_data  = fifo_head;

  always_ff @(posedge clock) begin
    if (reset) begin
      drop_cnt_reg <= 4'd0;
      bug_reg      <= 1'b0;
    end else if (fifo_ovf) begin
      if (drop_cnt_reg != 4'hF) begin
        drop_cnt_reg <= drop_cnt_reg + 4'd1;
      end
      bug_reg <= 1'b1;
    end
  end

  assign drop_cnt = drop_cnt_reg;
  assign bug      = bug_reg;

  // Coverage survives reset; the lookup uses last cycle's registered tuple.
  always_ff @(posedge clock) begin
    cov_state_reg <= cov_tuple(state_reg, fifo_count, idle_reg);
    if (meta_reset) begin
      covmap_reg <= '0;
      covsum_reg <= '0;
    end else if (!covmap_reg[cov_state_reg]) begin
      covmap_reg[cov_state_reg] <= 1'b1;
      covsum_reg                <= covsum_reg + 1'b1;
    end
  end

  assign coverage   = covsum_reg;
  assign io_cov_sum = covsum_reg;

  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_mem_resp_packer.sv
// Randomised and directed bench for mem_resp_packer against a queue-based model.
module tb_mem_resp_packer;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 3;

  logic       clock;
  logic       reset;
  logic       meta_reset;
  logic [3:0] drop_cnt;
  logic [5:0] coverage;
  logic [5:0] io_cov_sum;
  logic       bug;

  mem_resp_packer_if bus ();

  mem_resp_packer #(
    .DEPTH  (DEPTH),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .meta_reset(meta_reset),
    .bus       (bus),
    .drop_cnt  (drop_cnt),
    .coverage  (coverage),
    .io_cov_sum(io_cov_sum),
    .bug       (bug)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model: byte queue plus spec-level packer and coverage bookkeeping.
  logic [7:0] q[$];
  bit         m_state;
  logic [3:0] m_lo;
  logic [1:0] m_idle;
  int         m_drop;
  bit         m_bug;
  bit         cov_seen[64];
  int         m_cov;
  logic [5:0] m_prev;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    check_value("out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
    if (q.size() > 0) check_value("out_data", 32'(bus.out_data), 32'(q[0]));
    check_value("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    check_value("bug", 32'(bug), 32'(m_bug));
    check_value("coverage", 32'(coverage), 32'(m_cov));
    check_value("io_cov_sum", 32'(io_cov_sum), 32'(m_cov));
  endtask

  task automatic model_edge(input bit iv, input logic [3:0] id, input bit rdy,
                            input bit rst, input bit mrst);
    logic [5:0] tup;
    bit         push;
    bit         pop;
    logic [7:0] pbyte;
    int         sz;
    tup = {m_state, 3'(q.size()), m_idle};
    if (mrst) begin
      foreach (cov_seen[k]) cov_seen[k] = 0;
      m_cov = 0;
    end else if (!cov_seen[m_prev]) begin
      cov_seen[m_prev] = 1;
      m_cov = (m_cov + 1) % 64;
    end
    m_prev = tup;
    if (rst) begin
      m_state = 0; m_lo = 0; m_idle = 0; m_drop = 0; m_bug = 0;
      q.delete();
      return;
    end
    push  = 0;
    pbyte = 8'h00;
    if (!m_state) begin
      if (iv) begin m_lo = id; m_idle = 0; m_state = 1; end
    end else if (iv) begin
      push = 1; pbyte = {id, m_lo}; m_state = 0;
    end else if (int'(m_idle) == TIMEOUT - 1) begin
      push = 1; pbyte = {4'h0, m_lo}; m_idle = 0; m_state = 0;
    end else begin
      m_idle = m_idle + 2'd1;
    end
    sz  = q.size();
    pop = (sz > 0) && rdy;
    if (pop) begin
      $display("pop  0x%02h", q[0]);
      void'(q.pop_front());
    end
    if (push) begin
      if (sz < DEPTH || pop) begin
        q.push_back(pbyte);
      end else begin
        $display("drop 0x%02h", pbyte);
        if (m_drop < 15) m_drop++;
        m_bug = 1;
      end
    end
  endtask

  // One clock: check outputs, drive inputs on the falling edge, update the model at the rising edge.
  task automatic step(input bit iv, input logic [3:0] id, input bit rdy, input bit rst, input bit mrst);
    @(negedge clock);
    check_model();
    bus.in_valid  = iv;
    bus.in_data   = id;
    bus.out_ready = rdy;
    reset         = rst;
    meta_reset    = mrst;
    @(posedge clock);
    model_edge(iv, id, rdy, rst, mrst);
  endtask

  logic [7:0] exp_ovf[4];
  logic [7:0] exp_wrap[4];

  initial begin
    exp_ovf  = '{8'h21, 8'h43, 8'h65, 8'h87};
    exp_wrap = '{8'h43, 8'h65, 8'h87, 8'hA9};
    clock         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 4'h0;
    bus.out_ready = 1'b0;
    reset         = 1'b1;
    meta_reset    = 1'b1;
    repeat (2) @(posedge clock);
    m_state = 0; m_lo = 0; m_idle = 0; m_drop = 0; m_bug = 0; m_cov = 0; m_prev = 6'd0;
    foreach (cov_seen[k]) cov_seen[k] = 0;
    #1;
    check_value("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_value("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    check_value("rst_bug", 32'(bug), 32'd0);
    check_value("meta_cov_zero", 32'(coverage), 32'd0);

    // Pack 0x3 then 0xA.
    step(1, 4'h3, 1, 0, 0);
    step(1, 4'hA, 1, 0, 0);
    #1;
    check_value("pack_valid", 32'(bus.out_valid), 32'd1);
    check_value("pack_byte", 32'(bus.out_data), 32'hA3);
    step(0, 4'h0, 1, 0, 0);
    #1 check_value("pack_empty", 32'(bus.out_valid), 32'd0);

    // Timeout flush of a lone 0x5.
    step(1, 4'h5, 0, 0, 0);
    step(0, 4'h0, 0, 0, 0);
    step(0, 4'h0, 0, 0, 0);
    #1 check_value("tmo_not_yet", 32'(bus.out_valid), 32'd0);
    step(0, 4'h0, 0, 0, 0);
    #1;
    check_value("tmo_valid", 32'(bus.out_valid), 32'd1);
    check_value("tmo_byte", 32'(bus.out_data), 32'h05);
    step(0, 4'h0, 1, 0, 0);

    // Overflow: ten nibbles into a stalled consumer.
    step(0, 4'h0, 0, 1, 0);
    for (int i = 1; i <= 10; i++) step(1, 4'(i), 0, 0, 0);
    #1;
    check_value("ovf_drop_cnt", 32'(drop_cnt), 32'd1);
    check_value("ovf_bug", 32'(bug), 32'd1);
    for (int i = 0; i < 4; i++) begin
      #1 check_value("ovf_drain", 32'(bus.out_data), 32'(exp_ovf[i]));
      step(0, 4'h0, 1, 0, 0);
    end
    #1 check_value("ovf_drained", 32'(bus.out_valid), 32'd0);

    // Full FIFO with push and pop on the same edge.
    step(0, 4'h0, 0, 1, 0);
    for (int i = 1; i <= 9; i++) step(1, 4'(i), 0, 0, 0);
    step(1, 4'hA, 1, 0, 0);
    #1;
    check_value("wrap_no_drop", 32'(drop_cnt), 32'd0);
    check_value("wrap_no_bug", 32'(bug), 32'd0);
    for (int i = 0; i < 4; i++) begin
      #1 check_value("wrap_drain", 32'(bus.out_data), 32'(exp_wrap[i]));
      step(0, 4'h0, 1, 0, 0);
    end
    #1 check_value("wrap_drained", 32'(bus.out_valid), 32'd0);

    // Reset mid-byte discards the low nibble.
    step(1, 4'h7, 1, 0, 0);
    step(0, 4'h0, 1, 1, 0);
    step(1, 4'h1, 1, 0, 0);
    step(1, 4'h2, 1, 0, 0);
    #1 check_value("midrst_byte", 32'(bus.out_data), 32'h21);
    step(0, 4'h0, 1, 0, 0);
    #1 check_value("midrst_empty", 32'(bus.out_valid), 32'd0);

    // Coverage: clear, idle, one pack, then reset must keep the sum.
    step(0, 4'h0, 1, 0, 1);
    #1 check_value("cov_cleared", 32'(coverage), 32'd0);
    repeat (3) step(0, 4'h0, 1, 0, 0);
    step(1, 4'h4, 1, 0, 0);
    step(1, 4'hB, 1, 0, 0);
    repeat (3) step(0, 4'h0, 1, 0, 0);
    step(0, 4'h0, 1, 1, 0);
    #1 check_value("cov_kept", 32'(coverage != 6'd0), 32'd1);

    // Random traffic: mostly-ready phase, then starved consumer for saturation.
    for (int c = 0; c < 500; c++)
      step($urandom_range(0, 9) < 7, 4'($urandom), $urandom_range(0, 3) != 0,
           $urandom_range(0, 63) == 0, $urandom_range(0, 99) == 0);
    for (int c = 0; c < 400; c++)
      step($urandom_range(0, 9) < 8, 4'($urandom), $urandom_range(0, 9) == 0,
           0, $urandom_range(0, 199) == 0);
    #1 check_value("drop_saturated", 32'(drop_cnt), 32'd15);
    step(0, 4'h0, 1, 0, 0);
    @(negedge clock);
    check_model();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/mem_resp_packer.md
# mem_resp_packer

Downstream stage of the memory controller. It consumes that controller's `out_valid`/`out_data` nibble stream and packs consecutive nibbles into bytes (first nibble low, second nibble high). Completed bytes go into a small show-ahead FIFO that drains over a valid/ready port. Like the other micro blocks, it carries a 64-entry state-coverage map with a `meta_reset` clear and a `bug` flag for the fuzzing harness.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, 2..4 (count must fit 3 bits).
- `TIMEOUT`, 3: idle cycles in HIGH before a padded flush; 1..3.
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high; clock `clock`. Clears datapath, FSM, FIFO, `drop_cnt`, `bug`; does not touch coverage.
- `meta_reset`  in  1  synchronous; clears covmap and covsum only.
- `in_valid`  in  1  nibble strobe, from mem_ctrl `out_valid`.
- `in_data`  in  4  nibble, from mem_ctrl `out_data`.
- `out_valid`  out  1  FIFO non-empty.
- `out_data`  out  8  FIFO head byte; undefined when `out_valid`=0.
- `out_ready`  in  1  consumer accepts head this cycle.
- `drop_cnt`  out  4  dropped bytes, saturating at 15.
- `coverage`  out  6  covsum.
- `io_cov_sum`  out  6  covsum (duplicate).
- `bug`  out  1  sticky overflow flag.

## Operation
- The input has no backpressure. Every `in_valid` cycle delivers one nibble.
- FSM has two states:
  - LOW (reset state): waiting for the low nibble.
  - HIGH: low nibble latched, waiting for the high nibble.
- In LOW with `in_valid`: latch `in_data` as lo, clear idle_cnt, go to HIGH.
- In HIGH with `in_valid`: push `{in_data, lo}`, go to LOW.
- In HIGH without `in_valid`: idle_cnt += 1. When idle_cnt == TIMEOUT-1 and `in_valid`=0, push `{4'h0, lo}`, clear idle_cnt, go to LOW.
- Pop occurs when `out_valid && out_ready`.
- A push succeeds if count < DEPTH or a pop happens in the same cycle; same-cycle push and pop on a full FIFO keeps count = DEPTH.
- A push with count == DEPTH and no pop is dropped:
  - FIFO contents unchanged;
  - `drop_cnt` increments, saturating at 15;
  - `bug` sets to 1 and holds until `reset`.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is 3 bits, range 0..DEPTH.
- Coverage:
  - Each cycle, reg_state <= {fsm(1), count(3), idle_cnt(2)}.
  - If covmap[reg_state] == 0: set it and add 1 to covsum.
  - `meta_reset` has priority and zeroes covsum and all covmap entries.
  - covsum and covmap initialise to 0 at time zero.

## Timing
- Reset values: `out_valid`=0, `drop_cnt`=0, `bug`=0, FSM=LOW, count=0, idle_cnt=0. `coverage` and `io_cov_sum` are unaffected by `reset`.
- Nibbles at edges t and t+k: byte is in the FIFO after edge t+k, so `out_valid`=1 from cycle t+k+1 (one-cycle latency).
- Back-to-back nibbles every cycle produce one byte per two cycles.
- Timeout flush: last nibble at t with no further input, so the padded byte is pushed at edge t+TIMEOUT.
- `out_data` is combinational from the head entry and stable while `out_valid`=1 and `out_ready`=0.
- `reset` mid-byte discards the latched lo nibble. `reset` with a full FIFO empties it, and `out_valid`=0 the next cycle.
- When `reset` and `in_valid` are high in the same cycle, `reset` wins and the nibble is lost.
- Coverage lags state by one cycle: reg_state is registered before the map lookup.

## Structure
- Package `mem_pkt_pkg` holds:
  - FSM enum (LOW=1'b0, HIGH=1'b1);
  - `COV_W`=6 and `COV_ENTRIES`=64;
  - `NIB_W`=4 and `BYTE_W`=8.
- Sub-module `byte_fifo` contains the DEPTH-parameterised show-ahead FIFO: push, pop, full, empty, count, and the head output. It reports a push rejected when full as a single-cycle `ovf` pulse.
- Top level holds the packer FSM, idle counter, drop counter, bug flag and coverage map.

## Test plan
- Pack: nibbles 0x3, 0xA on consecutive cycles with `out_ready`=1 -> `out_valid` one cycle later with `out_data`=0xA3, then empty.
- Timeout: single nibble 0x5 with TIMEOUT=3 -> `out_data`=0x05 appears 4 cycles after the nibble, and the FSM returns to LOW.
- Overflow: `out_ready`=0 while sending 10 nibbles -> 4 bytes held, `drop_cnt`=1, `bug`=1. Draining then yields the first 4 bytes in order.
- Full with simultaneous push and pop: full FIFO, `out_ready`=1 on the cycle a new byte completes -> no drop, count stays 4, order preserved across pointer wrap.
- Reset mid-byte: nibble 0x7, then `reset`, then nibbles 0x1, 0x2 -> only 0x21 is output.
- Coverage: `meta_reset` pulse -> `coverage`=0. Idle then one pack sequence -> covsum equals the number of distinct {fsm, count, idle_cnt} tuples visited, and `reset` does not clear it.
